// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: derives its own sample tick, synchronises the
// RX line, majority-votes three mid-bit samples per bit, deframes
// start/data/parity/stop and hands each word out over valid/ready.
`timescale 1ns/1ps
module uart_rx_sampler #(
  parameter int CLK_HZ       = 65_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int SAMP_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 sig_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 parity_err_out,
  output logic                 frame_err_out,
  output logic                 overrun_out,
  output logic                 busy_out
);

  localparam int DIV = CLK_HZ / (SAMP_PER_BIT * BAUD_RATE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(SAMP_PER_BIT);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int M   = SAMP_PER_BIT / 2;

  localparam logic [TW-1:0] DIV_LAST    = TW'(DIV - 1);
  localparam logic [SW-1:0] S_V0        = SW'(M - 1);
  localparam logic [SW-1:0] S_V1        = SW'(M);
  localparam logic [SW-1:0] S_DEC       = SW'(M + 1);
  localparam logic [SW-1:0] S_LAST      = SW'(SAMP_PER_BIT - 1);
  localparam logic [BW-1:0] B_DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_STOP_LAST = BW'(STOP_BITS - 1);

  if (DIV < 1) begin : g_div_err
    $error("uart_rx_sampler: CLK_HZ too low for BAUD_RATE*SAMP_PER_BIT");
  end
  if ((SAMP_PER_BIT < 4) || (SAMP_PER_BIT % 2 != 0)) begin : g_spb_err
    $error("uart_rx_sampler: SAMP_PER_BIT must be even and >= 4");
  end
  if (SYNC_STAGES < 2) begin : g_sync_err
    $error("uart_rx_sampler: SYNC_STAGES must be >= 2");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          div_q, div_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SW-1:0]          s_q, s_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   v0_q, v0_d, v1_q, v1_d;
  logic                   armed_q, armed_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   ferr_q, ferr_d;
  logic                   done_q, done_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_out_q, perr_out_d;
  logic                   ferr_out_q, ferr_out_d;
  logic                   ovr_q, ovr_d;

  logic tick, s_line, decision, at_dec, at_end;

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_err(input logic [DATA_BITS-1:0] d, input logic p);
    case (PARITY_MODE)
      1:       return (^d) ^ p;
      2:       return ~((^d) ^ p);
      default: return 1'b0;
    endcase
  endfunction

  assign tick     = (div_q == '0);
  assign s_line   = sync_q[SYNC_STAGES-1];
  assign decision = majority(v0_q, v1_q, s_line);
  assign at_dec   = tick && (s_q == S_DEC);
  assign at_end   = tick && (s_q == S_LAST);

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state: every transition happens on a sample tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (tick && !s_line && armed_q) state_d = ST_START;
      ST_START:  if (at_dec && decision) state_d = ST_IDLE;
                 else if (at_end) state_d = ST_DATA;
      ST_DATA:   if (at_dec && (bit_cnt_q == B_DATA_LAST))
                   state_d = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (at_dec) state_d = ST_STOP;
      ST_STOP:   if (at_dec && (bit_cnt_q == B_STOP_LAST)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs: busy reflects the FSM, the rest come straight from flops
  always_comb begin
    busy_out       = (state_q != ST_IDLE);
    data_out       = data_q;
    valid_out      = valid_q;
    parity_err_out = perr_out_q;
    frame_err_out  = ferr_out_q;
    overrun_out    = ovr_q;
  end

  // Datapath and handshake registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_q      <= '0;
      sync_q     <= '1;
      s_q        <= '0;
      bit_cnt_q  <= '0;
      v0_q       <= 1'b1;
      v1_q       <= 1'b1;
      armed_q    <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      sync_q     <= sync_d;
      s_q        <= s_d;
      bit_cnt_q  <= bit_cnt_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      armed_q    <= armed_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ferr_q     <= ferr_d;
      done_q     <= done_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  // Tick divider, sampling, bit assembly and word delivery
  always_comb begin
    div_d      = (div_q == '0) ? DIV_LAST : div_q - TW'(1);
    sync_d     = {sync_q[SYNC_STAGES-2:0], sig_in};
    s_d        = s_q;
    bit_cnt_d  = bit_cnt_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    armed_d    = armed_q;
    shift_d    = shift_q;
    par_d      = par_q;
    ferr_d     = ferr_q;
    done_d     = 1'b0;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = 1'b0;

    if (tick) begin
      if (state_q == ST_IDLE) begin
        // Sample phase restarts at the first low tick of a start bit
        s_d = '0;
        if (s_line) armed_d = 1'b1;
        else if (armed_q) begin
          bit_cnt_d = '0;
          ferr_d    = 1'b0;
        end
      end else begin
        s_d = (s_q == S_LAST) ? '0 : s_q + SW'(1);
        if (s_q == S_V0) v0_d = s_line;
        if (s_q == S_V1) v1_d = s_line;
      end
    end

    if (at_dec) begin
      case (state_q)
        ST_DATA: begin
          for (int i = 0; i < DATA_BITS; i++) begin
            if (bit_cnt_q == BW'(i)) shift_d[i] = decision;
          end
          bit_cnt_d = (bit_cnt_q == B_DATA_LAST) ? '0 : bit_cnt_q + BW'(1);
        end
        ST_PARITY: par_d = decision;
        ST_STOP: begin
          if (!decision) ferr_d = 1'b1;
          if (bit_cnt_q == B_STOP_LAST) begin
            done_d = 1'b1;
            // A held-low break must see the line go high before re-arming
            if (!decision || ferr_q) armed_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        default: ;
      endcase
    end

    if (done_q) begin
      if (!valid_q || ready_in) begin
        data_d     = shift_q;
        perr_out_d = parity_err(shift_q, par_q);
        ferr_out_d = ferr_q;
        valid_d    = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: an 8N1 instance and an 8E1 instance fed by
// bit-level frame tasks, with expected words queued at send time.
`timescale 1ns/1ps
module tb_uart_rx_sampler;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 10_000;
  localparam int SPB    = 16;
  localparam int BIT    = 160;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sig_m = 1'b1, sig_p = 1'b1;
  logic       ready_m = 1'b1, ready_p = 1'b1;
  logic [7:0] data_m, data_p;
  logic       valid_m, valid_p, perr_m, perr_p, ferr_m, ferr_p;
  logic       ovr_m, ovr_p, busy_m, busy_p;

  exp_t exp_m[$];
  exp_t exp_p[$];
  exp_t em, ep;

  int n_checks = 0;
  int n_errors = 0;
  int ovr_m_cnt = 0;
  int ovr_p_cnt = 0;

  always #5 clk = ~clk;

  uart_rx_sampler #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .SAMP_PER_BIT(SPB),
    .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .sig_in(sig_m), .data_out(data_m),
    .valid_out(valid_m), .ready_in(ready_m), .parity_err_out(perr_m),
    .frame_err_out(ferr_m), .overrun_out(ovr_m), .busy_out(busy_m));

  uart_rx_sampler #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .SAMP_PER_BIT(SPB),
    .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .SYNC_STAGES(2)) u_dut_par (
    .clk_in(clk), .rst_n_in(rst_n), .sig_in(sig_p), .data_out(data_p),
    .valid_out(valid_p), .ready_in(ready_p), .parity_err_out(perr_p),
    .frame_err_out(ferr_p), .overrun_out(ovr_p), .busy_out(busy_p));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard for the 8N1 instance
  always @(negedge clk) begin
    if (rst_n && valid_m && ready_m) begin
      if (exp_m.size() == 0) chk("m_word_pending", 32'(exp_m.size()), 32'd1);
      else begin
        em = exp_m.pop_front();
        chk("m_data", 32'(data_m), 32'(em.d));
        chk("m_parity_err", 32'(perr_m), 32'(em.pe));
        chk("m_frame_err", 32'(ferr_m), 32'(em.fe));
      end
    end
    if (ovr_m) ovr_m_cnt++;
  end

  // Scoreboard for the 8E1 instance
  always @(negedge clk) begin
    if (rst_n && valid_p && ready_p) begin
      if (exp_p.size() == 0) chk("p_word_pending", 32'(exp_p.size()), 32'd1);
      else begin
        ep = exp_p.pop_front();
        chk("p_data", 32'(data_p), 32'(ep.d));
        chk("p_parity_err", 32'(perr_p), 32'(ep.pe));
        chk("p_frame_err", 32'(ferr_p), 32'(ep.fe));
      end
    end
    if (ovr_p) ovr_p_cnt++;
  end

  task automatic set_line(input bit which, input logic v);
    if (which) sig_p = v;
    else       sig_m = v;
  endtask

  task automatic hold(input bit which, input logic v, input int n);
    set_line(which, v);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input bit par_en,
                            input logic pbit, input bit glitch, input bit chk_busy);
    hold(which, 1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      if (glitch && i == 0) begin
        hold(which, d[i], 80);
        hold(which, 1'b0, 10);
        hold(which, d[i], 70);
      end else begin
        hold(which, d[i], BIT);
      end
    end
    if (par_en) hold(which, pbit, BIT);
    if (chk_busy) begin
      hold(which, 1'b1, 60);
      @(negedge clk);
      chk("busy_before_stop_dec", 32'(busy_m), 32'd1);
      hold(which, 1'b1, 80);
      @(negedge clk);
      chk("busy_after_stop_dec", 32'(busy_m), 32'd0);
      hold(which, 1'b1, 20);
    end else begin
      hold(which, 1'b1, BIT);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_m.size() != 0 || exp_p.size() != 0) && n < 4 * BIT) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(exp_m.size() + exp_p.size()), 32'd0);
  endtask

  initial begin
    int busy_cnt;
    int ovr0;

    // Reset values
    #5 rst_n = 1'b0;
    #2;
    chk("rst_data", 32'(data_m), 32'd0);
    chk("rst_valid", 32'(valid_m), 32'd0);
    chk("rst_perr", 32'(perr_m), 32'd0);
    chk("rst_ferr", 32'(ferr_m), 32'd0);
    chk("rst_ovr", 32'(ovr_m), 32'd0);
    chk("rst_busy", 32'(busy_m), 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    hold(1'b0, 1'b1, 2 * BIT);

    // 1: 0xA5 with a one-tick glitch in data bit 0
    exp_m.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
    drain("drain_a5");

    // 2: 30-clk low pulse is a false start
    busy_cnt = 0;
    set_line(1'b0, 1'b0);
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (busy_m) busy_cnt++;
      if (i == 29) sig_m = 1'b1;
    end
    chk("false_start_busy_cycles", 32'(busy_cnt), 32'd100);
    chk("false_start_idle", 32'(busy_m), 32'd0);
    hold(1'b0, 1'b1, BIT);

    // 3: even parity, wrong then right parity bit
    exp_p.push_back('{d: 8'h07, pe: 1'b1, fe: 1'b0});
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    drain("drain_par_bad");
    exp_p.push_back('{d: 8'h07, pe: 1'b0, fe: 1'b0});
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    drain("drain_par_good");
    chk("par_busy_idle", 32'(busy_p), 32'd0);

    // 4: held break, then a clean frame
    exp_m.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
    hold(1'b0, 1'b0, 20 * BIT);
    hold(1'b0, 1'b1, 2 * BIT);
    chk("break_one_word", 32'(exp_m.size()), 32'd0);
    exp_m.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0});
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("drain_3c");

    // 5: consumer stalled, second frame overruns
    ready_m = 1'b0;
    ovr0 = ovr_m_cnt;
    exp_m.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("overrun_cycles", 32'(ovr_m_cnt - ovr0), 32'd1);
    chk("stall_valid", 32'(valid_m), 32'd1);
    chk("stall_data", 32'(data_m), 32'h11);
    @(posedge clk);
    #1 ready_m = 1'b1;
    @(posedge clk);
    #1 ready_m = 1'b0;
    @(negedge clk);
    chk("valid_cleared", 32'(valid_m), 32'd0);
    chk("stall_word_taken", 32'(exp_m.size()), 32'd0);
    ready_m = 1'b1;
    hold(1'b0, 1'b1, BIT);

    // 6: reset in the middle of 0x5A, then 0x81
    hold(1'b0, 1'b0, BIT);
    hold(1'b0, 1'b0, BIT);
    hold(1'b0, 1'b1, BIT);
    hold(1'b0, 1'b0, BIT);
    hold(1'b0, 1'b1, 80);
    chk("mid_frame_busy", 32'(busy_m), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    sig_m = 1'b1;
    #1;
    chk("arst_data", 32'(data_m), 32'd0);
    chk("arst_valid", 32'(valid_m), 32'd0);
    chk("arst_busy", 32'(busy_m), 32'd0);
    chk("arst_flags", {29'd0, perr_m, ferr_m, ovr_m}, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    hold(1'b0, 1'b1, 2 * BIT);
    exp_m.push_back('{d: 8'h81, pe: 1'b0, fe: 1'b0});
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("drain_81");

    hold(1'b0, 1'b1, BIT);
    chk("overrun_total", 32'(ovr_m_cnt), 32'd1);
    chk("par_overrun_total", 32'(ovr_p_cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
Parametrised oversampling UART receiver, successor to the single-rate sampler block.
- Generates its own oversample tick and synchronises the asynchronous RX line.
- Majority-votes three mid-bit samples per bit and deframes start/data/parity/stop.
- Delivers each word through a valid/ready handshake, with parity, framing and overrun flags.
- Sits between the board RX pin and the command/packet parsers.

Parameters:
CLK_HZ, 65_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate
SAMP_PER_BIT, 16, oversample ticks per bit; even, >=4
DATA_BITS, 8, data bits per frame, 5..9, sent LSB first
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
SYNC_STAGES, 2, synchroniser depth on sig_in, >=2

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  reset, asynchronous assert, active-low
sig_in  input  1  raw RX line, asynchronous, idle high
data_out  output  DATA_BITS  received word
valid_out  output  1  data_out/flags hold a word
ready_in  input  1  consumer accepts the word when valid_out & ready_in
parity_err_out  output  1  parity mismatch for the held word; 0 when PARITY_MODE=0
frame_err_out  output  1  a stop bit was sampled low for the held word
overrun_out  output  1  one-cycle pulse: a frame was dropped
busy_out  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk_in; reset is asynchronous and active-low, rst_n_in.
- Reset values:
  - data_out = 0; valid_out, parity_err_out, frame_err_out, overrun_out and busy_out = 0.
  - Synchroniser flops = 1; state = IDLE; armed = 0.
- Divider:
  - DIV = CLK_HZ/(SAMP_PER_BIT*BAUD_RATE), integer division; elaboration error if DIV < 1.
  - Free-running down-counter, reloads DIV-1 at 0; tick = 1 for the cycle where the count is 0.
- Sampling: all sampling and state advance happen only on tick cycles, using the synchronised line s_line.
- Sample counter and votes:
  - Sample counter s runs 0..SAMP_PER_BIT-1, wrapping; M = SAMP_PER_BIT/2.
  - Votes are taken at s = M-1, M, M+1; bit value = majority (>=2 of 3).
  - The bit decision is made at s = M+1.
- IDLE:
  - On a tick with s_line = 1, set armed = 1.
  - On a tick with s_line = 0 and armed = 1, go to START with s = 0.
  - armed = 0 after a framing error, so a held break never retriggers reception.
- START: if the decision = 1 (false start/glitch), return to IDLE at once with no outputs; otherwise advance to DATA at s = SAMP_PER_BIT-1.
- DATA:
  - Shift the decision into bit position bit_cnt, LSB first.
  - After DATA_BITS bits, go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY:
  - Even mode: error if XOR(data, bit) = 1.
  - Odd mode: error if XOR(data, bit) = 0.
- STOP:
  - A decision of 0 on any stop bit sets frame error.
  - On the final stop bit, go to IDLE immediately after the decision, not at the end of the bit. This leaves half a bit of margin for back-to-back frames.
- Completion (clock after the final stop decision):
  - If valid_out = 0, or ready_in = 1 in that same cycle: load data_out and both error flags, and set valid_out = 1.
  - Else: the new frame is dropped, data_out and flags are unchanged, and overrun_out pulses for 1 cycle.
  - Errored frames are still delivered, with their flags set.
- Handshake:
  - valid_out clears the cycle after valid_out & ready_in, unless a completion loads a new word in that same cycle.
  - data_out is stable while valid_out = 1.
- Reset mid-frame: all state is cleared asynchronously and no partial word is emitted; armed = 0, so the first idle-high tick is required before the next frame.
- Widths:
  - Tick counter: max(1, $clog2(DIV)).
  - Sample counter: $clog2(SAMP_PER_BIT).
  - Bit counter: $clog2(DATA_BITS+1).

Test Plan:
Bench settings: CLK_HZ=1_600_000, BAUD_RATE=10_000, SAMP_PER_BIT=16 (DIV=10, 160 clk/bit), ready_in=1 unless stated.
1. 8N1 frame 0xA5, with a single 1-tick low glitch at s = M of data bit 0 -> valid_out pulse with data_out = 0xA5, all error flags 0; busy_out falls at the stop decision.
2. sig_in low for 30 clk, then high -> no valid_out; busy_out high for at most 10 ticks, then IDLE.
3. PARITY_MODE=1, data 0x07 with parity bit 0 -> data_out = 0x07, parity_err_out = 1; repeat with parity bit 1 -> parity_err_out = 0.
4. Line held low for 20 bit times, then high, then 0x3C:
   - First: one word 0x00 with frame_err_out = 1.
   - No further words while the line stays low.
   - Then 0x3C with no errors.
5. ready_in = 0; send 0x11 then 0x22 back-to-back -> data_out stays 0x11, and overrun_out is high for exactly 1 clk. Then pulse ready_in -> valid_out = 0 on the next clk.
6. rst_n_in low for 3 clk in mid-DATA of 0x5A:
   - All outputs are 0 asynchronously and no word is emitted.
   - The next frame 0x81 is received correctly.
